// File: rtl/edge_seq_pkg.sv
// Shared types and constants for the edge counter
// run sequencer.
package edge_seq_pkg;

  localparam int NUM_CH         = 4;
  localparam int CLR_CYCLES_DEF = 2;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ARMED,
    GAP,
    DONE
  } seq_state_e;

endpackage

// File: rtl/edge_seq_timer.sv
// Loadable up/down counter shared by the low-time
// windows and the armed-window timeout.
module edge_seq_timer #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  input  logic         up_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i) begin
      if (up_i) begin
        if (cnt_q != '1) cnt_d = cnt_q + W'(1);
      end else begin
        if (cnt_q != '0) cnt_d = cnt_q - W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
  // up: saturated; down: expired
  assign tc_o  = up_i ? (&cnt_q) : (cnt_q == '0);

endmodule

// File: rtl/edge_counter_sequencer.sv
// Run controller: arms the edge counter channels, waits
// for d3 capture or timeout, repeats for N runs.
module edge_counter_sequencer
  import edge_seq_pkg::*;
#(
  parameter int CLR_CYCLES = CLR_CYCLES_DEF,
  parameter int TMO_W      = 32,
  parameter int RUN_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [NUM_CH-1:0] cfg_ch_mask,
  input  logic [NUM_CH-1:0] cfg_trig_mask,
  input  logic [TMO_W-1:0]  cfg_timeout,
  input  logic [RUN_W-1:0]  cfg_num_runs,
  input  logic [15:0]       cfg_gap,
  input  logic [31:0]       d3_count_0,
  input  logic [31:0]       d3_count_1,
  input  logic [31:0]       d3_count_2,
  input  logic [31:0]       d3_count_3,
  output logic [NUM_CH-1:0] cfg_enable,
  output logic [NUM_CH-1:0] cfg_trig_enable,
  output logic              busy,
  output logic              done,
  output logic              timeout_flag,
  output logic              abort_flag,
  output logic [NUM_CH-1:0] ch_complete,
  output logic [RUN_W-1:0]  runs_done,
  output logic [RUN_W-1:0]  run_fail_count
);

  seq_state_e        state_q, state_d;
  logic [NUM_CH-1:0] mask_q, trig_q;
  logic [TMO_W-1:0]  tmo_q;
  logic [RUN_W-1:0]  nruns_q;
  logic [15:0]       gap_q;

  logic              tflag_q, tflag_d;
  logic              aflag_q, aflag_d;
  logic [NUM_CH-1:0] chc_q, chc_d;
  logic [RUN_W-1:0]  runs_q, runs_d;
  logic [RUN_W-1:0]  fail_q, fail_d;

  logic              accept;
  logic [NUM_CH-1:0] d3_nz, comp;
  logic              all_done, tmo_hit, last_run;
  logic [RUN_W:0]    runs_nx, runs_eff;
  logic [TMO_W-1:0]  gap_len;

  logic              tmr_load, tmr_en, tmr_up, tmr_tc;
  logic [TMO_W-1:0]  tmr_val, tmr_cnt;

  assign accept = (state_q == IDLE) && start && !abort;

  assign d3_nz = {d3_count_3 != '0, d3_count_2 != '0,
                  d3_count_1 != '0, d3_count_0 != '0};
  assign comp     = mask_q & d3_nz;
  assign all_done = (comp == mask_q);
  assign tmo_hit  = (tmo_q != '0) &&
                    (tmr_cnt == tmo_q - TMO_W'(1));

  assign runs_nx  = {1'b0, runs_q} + (RUN_W+1)'(1);
  assign runs_eff = (nruns_q == '0) ? (RUN_W+1)'(1)
                                    : {1'b0, nruns_q};
  assign last_run = (runs_nx >= runs_eff);

  assign gap_len = (TMO_W'(gap_q) < TMO_W'(CLR_CYCLES))
                 ? TMO_W'(CLR_CYCLES) : TMO_W'(gap_q);

  assign tmr_up = (state_q == ARMED);

  edge_seq_timer #(.W(TMO_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .en_i       (tmr_en),
    .up_i       (tmr_up),
    .cnt_o      (tmr_cnt),
    .tc_o       (tmr_tc)
  );

  always_comb begin
    state_d  = state_q;
    tflag_d  = tflag_q;
    aflag_d  = aflag_q;
    chc_d    = chc_q;
    runs_d   = runs_q;
    fail_d   = fail_q;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    tmr_val  = '0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = CLEAR;
          tflag_d  = 1'b0;
          aflag_d  = 1'b0;
          chc_d    = '0;
          runs_d   = '0;
          fail_d   = '0;
          tmr_load = 1'b1;
          tmr_val  = TMO_W'(CLR_CYCLES - 1);
        end
      end
      CLEAR: begin
        tmr_en = 1'b1;
        if (tmr_tc) begin
          if (mask_q == '0) begin
            state_d = DONE;
          end else begin
            state_d  = ARMED;
            tmr_load = 1'b1;
          end
        end
      end
      ARMED: begin
        tmr_en = 1'b1;
        // completion takes precedence over a same-cycle timeout
        if (all_done || tmo_hit) begin
          chc_d  = comp;
          runs_d = runs_q + RUN_W'(1);
          if (!all_done) begin
            tflag_d = 1'b1;
            fail_d  = (&fail_q) ? fail_q
                                : fail_q + RUN_W'(1);
          end
          if (last_run) begin
            state_d = DONE;
          end else begin
            state_d  = GAP;
            tmr_load = 1'b1;
            tmr_val  = gap_len - TMO_W'(1);
          end
        end
      end
      GAP: begin
        tmr_en = 1'b1;
        if (tmr_tc) begin
          state_d  = ARMED;
          tmr_load = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      aflag_d = 1'b1;
      tflag_d = tflag_q;
      chc_d   = chc_q;
      runs_d  = runs_q;
      fail_d  = fail_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tflag_q <= 1'b0;
      aflag_q <= 1'b0;
      chc_q   <= '0;
      runs_q  <= '0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      tflag_q <= tflag_d;
      aflag_q <= aflag_d;
      chc_q   <= chc_d;
      runs_q  <= runs_d;
      fail_q  <= fail_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q  <= '0;
      trig_q  <= '0;
      tmo_q   <= '0;
      nruns_q <= '0;
      gap_q   <= '0;
    end else if (accept) begin
      mask_q  <= cfg_ch_mask;
      trig_q  <= cfg_trig_mask;
      tmo_q   <= cfg_timeout;
      nruns_q <= cfg_num_runs;
      gap_q   <= cfg_gap;
    end
  end

  assign cfg_enable      = (state_q == ARMED) ? mask_q : '0;
  assign cfg_trig_enable = (state_q == ARMED) ? (mask_q & trig_q)
                                              : '0;
  assign busy            = (state_q != IDLE);
  assign done            = (state_q == DONE) && !abort;
  assign timeout_flag    = tflag_q;
  assign abort_flag      = aflag_q;
  assign ch_complete     = chc_q;
  assign runs_done       = runs_q;
  assign run_fail_count  = fail_q;

endmodule

// File: tb/tb_edge_counter_sequencer.sv
// Randomized bench for edge_counter_sequencer against a
// run-timeline model built from the sequencing rules.
module tb_edge_counter_sequencer;

  localparam int CLR   = 2;
  localparam int MAXC  = 512;
  localparam int NEVER = 1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [3:0]  cfg_ch_mask = '0;
  logic [3:0]  cfg_trig_mask = '0;
  logic [31:0] cfg_timeout = '0;
  logic [7:0]  cfg_num_runs = '0;
  logic [15:0] cfg_gap = '0;
  logic [31:0] d3_0 = '0;
  logic [31:0] d3_1 = '0;
  logic [31:0] d3_2 = '0;
  logic [31:0] d3_3 = '0;

  logic [3:0]  cfg_enable, cfg_trig_enable;
  logic        busy, done, timeout_flag, abort_flag;
  logic [3:0]  ch_complete;
  logic [7:0]  runs_done, run_fail_count;

  edge_counter_sequencer #(
    .CLR_CYCLES (CLR),
    .TMO_W      (32),
    .RUN_W      (8)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .abort           (abort),
    .cfg_ch_mask     (cfg_ch_mask),
    .cfg_trig_mask   (cfg_trig_mask),
    .cfg_timeout     (cfg_timeout),
    .cfg_num_runs    (cfg_num_runs),
    .cfg_gap         (cfg_gap),
    .d3_count_0      (d3_0),
    .d3_count_1      (d3_1),
    .d3_count_2      (d3_2),
    .d3_count_3      (d3_3),
    .cfg_enable      (cfg_enable),
    .cfg_trig_enable (cfg_trig_enable),
    .busy            (busy),
    .done            (done),
    .timeout_flag    (timeout_flag),
    .abort_flag      (abort_flag),
    .ch_complete     (ch_complete),
    .runs_done       (runs_done),
    .run_fail_count  (run_fail_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {busy, done, enable[3:0], trig_enable[3:0]} per cycle
  logic [9:0] exp_v [MAXC];
  logic [3:0] nz_v  [MAXC];

  bit         m_tflag, m_aflag;
  logic [3:0] m_ch;
  int         m_runs, m_fail;

  function automatic logic [31:0] nzval();
    return 32'($urandom) | 32'd1;
  endfunction

  function automatic logic [31:0] all_outs();
    return {busy, done, cfg_enable, cfg_trig_enable,
            timeout_flag, abort_flag, ch_complete,
            runs_done, run_fail_count};
  endfunction

  task automatic check_flags(input string tag);
    check({tag, "_tflag"}, 64'(timeout_flag), 64'(m_tflag));
    check({tag, "_aflag"}, 64'(abort_flag), 64'(m_aflag));
    check({tag, "_chc"}, 64'(ch_complete), 64'(m_ch));
    check({tag, "_runs"}, 64'(runs_done), 64'(m_runs));
    check({tag, "_fails"}, 64'(run_fail_count), 64'(m_fail));
  endtask

  // mode 0: full sequence, 1: abort, 2: reset while armed
  task automatic run_seq(input int mode);
    logic [3:0] mask, trig, comp;
    int tmo, nr, gap, gl, runs_eff, cur, done_c;
    int xa, rr, last, lc, lt, len;
    int t [4];
    int run_end [4];
    logic [3:0] run_ch [4];
    bit run_to [4];
    bit picked;
    mask = 4'($urandom_range(0, 15));
    if (mode == 2 && mask == 4'd0) mask = 4'b0100;
    trig = 4'($urandom_range(0, 15));
    tmo  = ($urandom_range(0, 2) == 0) ? 0
                                       : int'($urandom_range(5, 40));
    nr   = $urandom_range(0, 3);
    runs_eff = (nr == 0) ? 1 : nr;
    gap  = $urandom_range(0, 12);
    gl   = (gap < CLR) ? CLR : gap;
    for (int c = 0; c < MAXC; c++) begin
      exp_v[c] = '0;
      nz_v[c]  = '0;
    end
    for (int c = 1; c <= CLR; c++) exp_v[c][9] = 1'b1;
    cur = 1 + CLR;
    for (int r = 0; r < 4; r++) run_end[r] = NEVER;
    if (mask != 4'd0) begin
      for (int r = 0; r < runs_eff; r++) begin
        for (int i = 0; i < 4; i++)
          t[i] = (tmo != 0 && $urandom_range(0, 4) == 0)
               ? NEVER : int'($urandom_range(0, 45));
        if (tmo != 0 && $urandom_range(0, 3) == 0) begin
          picked = 1'b0;
          for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
              if (t[i] > tmo - 1) t[i] = tmo - 1;
              if (!picked) begin
                t[i] = tmo - 1;
                picked = 1'b1;
              end
            end
          end
        end
        lc = 0;
        for (int i = 0; i < 4; i++)
          if (mask[i] && t[i] + 1 > lc) lc = t[i] + 1;
        lt  = (tmo == 0) ? 2 * NEVER : tmo;
        len = (lc <= lt) ? lc : lt;
        comp = '0;
        for (int i = 0; i < 4; i++)
          if (mask[i] && t[i] < len) comp[i] = 1'b1;
        for (int c = cur; c < cur + len; c++) begin
          exp_v[c] = {2'b10, mask, mask & trig};
          for (int i = 0; i < 4; i++)
            nz_v[c][i] = (c - cur >= t[i]);
        end
        run_end[r] = cur + len - 1;
        run_ch[r]  = comp;
        run_to[r]  = (comp != mask);
        cur += len;
        if (r < runs_eff - 1) begin
          for (int c = cur; c < cur + gl; c++) exp_v[c][9] = 1'b1;
          cur += gl;
        end
      end
    end
    done_c = cur;
    exp_v[done_c] = 10'b11_0000_0000;
    xa = NEVER;
    rr = NEVER;
    last = done_c + 1;
    if (mode == 1) begin
      xa = $urandom_range(1, done_c - 1);
      for (int c = xa + 1; c < MAXC; c++) exp_v[c] = '0;
      last = xa + 2;
    end
    if (mode == 2)
      rr = 1 + CLR + $urandom_range(0, run_end[0] - (1 + CLR));

    for (int c = 0; c <= last; c++) begin
      @(posedge clk);
      #1;
      start = (c == 0) || (c >= 1 && c <= done_c && c <= xa &&
                           $urandom_range(0, 9) == 0);
      abort = (c == xa);
      if (c == 0) begin
        cfg_ch_mask   = mask;
        cfg_trig_mask = trig;
        cfg_timeout   = 32'(tmo);
        cfg_num_runs  = 8'(nr);
        cfg_gap       = 16'(gap);
      end else begin
        cfg_ch_mask   = 4'($urandom);
        cfg_trig_mask = 4'($urandom);
        cfg_timeout   = 32'($urandom_range(1, 9));
        cfg_num_runs  = 8'($urandom);
        cfg_gap       = 16'($urandom_range(0, 30));
      end
      d3_0 = nz_v[c][0] ? nzval() : '0;
      d3_1 = nz_v[c][1] ? nzval() : '0;
      d3_2 = nz_v[c][2] ? nzval() : '0;
      d3_3 = nz_v[c][3] ? nzval() : '0;
      if (c == rr) begin
        #2 rst_n = 1'b0;
        #1 check("rst_async", 64'(all_outs()), 64'd0);
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        rst_n = 1'b1;
        m_tflag = 1'b0;
        m_aflag = 1'b0;
        m_ch    = '0;
        m_runs  = 0;
        m_fail  = 0;
        check_flags("post_rst");
        break;
      end
      @(negedge clk);
      check("cyc", 64'({busy, done, cfg_enable, cfg_trig_enable}),
            64'(exp_v[c]));
    end
    start = 1'b0;
    abort = 1'b0;
    if (mode != 2) begin
      m_tflag = 1'b0;
      m_aflag = (mode == 1);
      m_ch    = '0;
      m_runs  = 0;
      m_fail  = 0;
      if (mask != 4'd0) begin
        for (int r = 0; r < runs_eff; r++) begin
          if (run_end[r] < xa) begin
            m_runs++;
            m_ch = run_ch[r];
            if (run_to[r]) begin
              m_tflag = 1'b1;
              m_fail++;
            end
          end
        end
      end
      check_flags(mode == 1 ? "abort" : "seq");
    end
  endtask

  // start and abort together while idle: nothing happens
  task automatic start_abort_idle();
    @(posedge clk);
    #1;
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    check("sa_busy", 64'(busy), 64'd0);
    check_flags("sa");
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m_tflag = 1'b0;
    m_aflag = 1'b0;
    m_ch    = '0;
    m_runs  = 0;
    m_fail  = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset", 64'(all_outs()), 64'd0);
    rst_n = 1'b1;
    for (int s = 0; s < 40; s++) begin
      run_seq((s % 5 == 3) ? 1 : (s % 5 == 4) ? 2 : 0);
      if (s % 5 == 3 || s % 5 == 0) start_abort_idle();
    end
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
